alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_TIMEOUT, default 60, ring duration in tick_1hz pulses before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300, snooze duration in tick_1hz pulses.
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 clk  in  1  system clock; all logic on rising edge, single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tick_1hz  in  1  one-cycle pulse, once per second.
REQ-007 adjust  in  1  1 = time/alarm being set, 0 = clock mode.
REQ-008 alarm_en  in  1  alarm arm switch, level.
REQ-009 time_h / time_m / time_s  in  5/6/6  current time, binary 0-23 / 0-59 / 0-59.
REQ-010 alarm_h / alarm_m  in  5/6  alarm time, binary.
REQ-011 stop  in  1  debounced one-cycle pulse.
REQ-012 snooze  in  1  debounced one-cycle pulse.
REQ-013 ringing  out  1  1 while in RING.
REQ-014 snoozing  out  1  1 while in SNOOZE.
REQ-015 alarm_led  out  1  blink output, toggles per tick in RING.
REQ-016 buzzer  out  1  ringing AND alarm_led.
REQ-017 snooze_cnt  out  2  snoozes used in current alarm event.

Function
REQ-018 States SHALL be IDLE, ARMED, RING, SNOOZE; all outputs registered.
REQ-019 match SHALL be (time_h==alarm_h && time_m==alarm_m && time_s==0); match_q = match registered one cycle.
REQ-020 Trigger SHALL be match && !match_q (rising edge), so a held match fires once.
REQ-021 IDLE -> ARMED when adjust==0 && alarm_en==1; otherwise stay.
REQ-022 ARMED -> RING on trigger; on entry sec_cnt=0, alarm_led=1, snooze_cnt=0.
REQ-023 RING: each tick_1hz toggles alarm_led and increments sec_cnt.
REQ-024 RING -> ARMED on stop; all ring outputs 0, snooze_cnt=0.
REQ-025 RING -> SNOOZE on snooze when snooze_cnt<MAX_SNOOZE; snooze_cnt+1, sec_cnt=0, alarm_led=0.
REQ-026 Snooze when snooze_cnt==MAX_SNOOZE SHALL be treated as stop.
REQ-027 RING -> ARMED when tick_1hz raises sec_cnt to RING_TIMEOUT with no button that cycle.
REQ-028 SNOOZE: each tick_1hz increments sec_cnt; at SNOOZE_SEC -> RING, sec_cnt=0, alarm_led=1, snooze_cnt kept.
REQ-029 SNOOZE -> ARMED on stop; snooze pulses in SNOOZE ignored.
REQ-030 Trigger in RING or SNOOZE SHALL be ignored.
REQ-031 Priority same cycle: adjust/!alarm_en > stop > snooze > timeout/tick.
REQ-032 adjust==1 or alarm_en==0 in any state -> IDLE next cycle, all outputs 0, counters 0.
REQ-033 sec_cnt width SHALL hold max(RING_TIMEOUT, SNOOZE_SEC); no wrap in any state.
REQ-034 Latency: state/outputs update on the clock edge after the causing input cycle.

Reset
REQ-035 rst SHALL force IDLE, ringing=0, snoozing=0, alarm_led=0, buzzer=0, snooze_cnt=0, sec_cnt=0, match_q=0, overriding all inputs.
REQ-036 rst mid-RING or mid-SNOOZE SHALL abort the event; no ring until a new trigger after rearming.

Verification
REQ-037 alarm 07:30, armed, time steps 07:29:59 -> 07:30:00 -> ringing=1, alarm_led=1 next cycle; alarm_led toggles on each later tick.
REQ-038 ringing, no button, 60 ticks -> ringing=0, ARMED; time held at 07:30:00 does not retrigger.
REQ-039 ringing, snooze pulse -> snoozing=1, snooze_cnt=1; 300 ticks -> ringing=1, snooze_cnt=1.
REQ-040 three snoozes used, 4th snooze pulse -> ringing=0, snooze_cnt=0, ARMED.
REQ-041 stop and snooze same cycle during RING -> ARMED, snooze_cnt=0.
REQ-042 adjust=1 during RING -> IDLE, all outputs 0; adjust=0 -> ARMED; rst mid-SNOOZE -> IDLE, outputs 0.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm-clock ring/snooze sequencer.
// Watches the current time against the alarm time. When the armed alarm
// matches, it rings with a blinking LED and buzzer. The user can stop the
// ring, or snooze it a limited number of times per alarm event. Adjust mode
// or disarming returns the block to IDLE from any state. Every output is
// registered.
module alarm_sequencer #(
    parameter int RING_TIMEOUT = 60,   // ring length in tick_1hz pulses before auto-stop
    parameter int SNOOZE_SEC   = 300,  // snooze length in tick_1hz pulses
    parameter int MAX_SNOOZE   = 3     // snoozes allowed per alarm event (0..3)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       adjust,
    input  logic       alarm_en,
    input  logic [4:0] time_h,
    input  logic [5:0] time_m,
    input  logic [5:0] time_s,
    input  logic [4:0] alarm_h,
    input  logic [5:0] alarm_m,
    input  logic       stop,
    input  logic       snooze,
    output logic       ringing,
    output logic       snoozing,
    output logic       alarm_led,
    output logic       buzzer,
    output logic [1:0] snooze_cnt
);

    // The second counter must reach the larger of the two durations without wrapping.
    localparam int CNT_MAX = (RING_TIMEOUT > SNOOZE_SEC) ? RING_TIMEOUT : SNOOZE_SEC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RING_LIMIT   = CNT_W'(RING_TIMEOUT);
    localparam logic [CNT_W-1:0] SNOOZE_LIMIT = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       SNOOZE_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RING   = 2'd2,
        SNOOZE = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] sec_cnt_q;
    logic [CNT_W-1:0] sec_cnt_d;
    logic [CNT_W-1:0] sec_inc;
    logic             match;
    logic             match_q;
    logic             trigger;
    logic             disarm;
    logic             led_d;
    logic [1:0]       snooze_cnt_d;
    logic             ringing_d;
    logic             snoozing_d;
    logic             buzzer_d;

    // The alarm matches for a whole second, so only the first cycle of a match may fire it.
    assign match   = (time_h == alarm_h) && (time_m == alarm_m) && (time_s == 6'd0);
    assign trigger = match && !match_q;
    assign disarm  = adjust || !alarm_en;
    assign sec_inc = sec_cnt_q + CNT_ONE;

    // Next-state, counter and output decode; the disarm override outranks every button and tick.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        led_d        = alarm_led;
        snooze_cnt_d = snooze_cnt;

        if (disarm) begin
            state_d      = IDLE;
            sec_cnt_d    = '0;
            led_d        = 1'b0;
            snooze_cnt_d = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Not disarmed means clock mode with the alarm switch on.
                    state_d      = ARMED;
                    sec_cnt_d    = '0;
                    led_d        = 1'b0;
                    snooze_cnt_d = 2'd0;
                end

                ARMED: begin
                    if (trigger) begin
                        state_d      = RING;
                        sec_cnt_d    = '0;
                        led_d        = 1'b1;
                        snooze_cnt_d = 2'd0;
                    end
                end

                RING: begin
                    // An exhausted snooze behaves exactly like stop.
                    if (stop || (snooze && (snooze_cnt >= SNOOZE_MAX))) begin
                        state_d      = ARMED;
                        sec_cnt_d    = '0;
                        led_d        = 1'b0;
                        snooze_cnt_d = 2'd0;
                    end else if (snooze) begin
                        state_d      = SNOOZE;
                        sec_cnt_d    = '0;
                        led_d        = 1'b0;
                        snooze_cnt_d = snooze_cnt + 2'd1;
                    end else if (tick_1hz) begin
                        if (sec_inc == RING_LIMIT) begin
                            // Nobody answered: give up on this event and rearm.
                            state_d      = ARMED;
                            sec_cnt_d    = '0;
                            led_d        = 1'b0;
                            snooze_cnt_d = 2'd0;
                        end else begin
                            sec_cnt_d = sec_inc;
                            led_d     = !alarm_led;
                        end
                    end
                end

                SNOOZE: begin
                    // Snooze presses while already snoozing are ignored.
                    if (stop) begin
                        state_d      = ARMED;
                        sec_cnt_d    = '0;
                        led_d        = 1'b0;
                        snooze_cnt_d = 2'd0;
                    end else if (tick_1hz) begin
                        if (sec_inc == SNOOZE_LIMIT) begin
                            // Snooze used up: ring again, keeping the snooze count.
                            state_d   = RING;
                            sec_cnt_d = '0;
                            led_d     = 1'b1;
                        end else begin
                            sec_cnt_d = sec_inc;
                        end
                    end
                end

                default: begin
                    state_d      = IDLE;
                    sec_cnt_d    = '0;
                    led_d        = 1'b0;
                    snooze_cnt_d = 2'd0;
                end
            endcase
        end
    end

    // Outputs are a pure function of the next state, so they can be registered alongside it.
    always_comb begin
        ringing_d  = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
        buzzer_d   = ringing_d && led_d;
    end

    // State, counters, match history and registered outputs; rst aborts any event in progress.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= IDLE;
            sec_cnt_q  <= '0;
            match_q    <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            alarm_led  <= 1'b0;
            buzzer     <= 1'b0;
            snooze_cnt <= 2'd0;
        end else begin
            state_q    <= state_d;
            sec_cnt_q  <= sec_cnt_d;
            match_q    <= match;
            ringing    <= ringing_d;
            snoozing   <= snoozing_d;
            alarm_led  <= led_d;
            buzzer     <= buzzer_d;
            snooze_cnt <= snooze_cnt_d;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Testbench for alarm_sequencer: a directed vector table followed by
// hand-written sequences for the long timeout and snooze runs.
module tb_alarm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic       adjust;
    logic       alarm_en;
    logic [4:0] time_h;
    logic [5:0] time_m;
    logic [5:0] time_s;
    logic [4:0] alarm_h;
    logic [5:0] alarm_m;
    logic       stop;
    logic       snooze;
    logic       ringing;
    logic       snoozing;
    logic       alarm_led;
    logic       buzzer;
    logic [1:0] snooze_cnt;

    int total = 0;
    int bad   = 0;

    alarm_sequencer #(
        .RING_TIMEOUT(60),
        .SNOOZE_SEC  (300),
        .MAX_SNOOZE  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .adjust    (adjust),
        .alarm_en  (alarm_en),
        .time_h    (time_h),
        .time_m    (time_m),
        .time_s    (time_s),
        .alarm_h   (alarm_h),
        .alarm_m   (alarm_m),
        .stop      (stop),
        .snooze    (snooze),
        .ringing   (ringing),
        .snoozing  (snoozing),
        .alarm_led (alarm_led),
        .buzzer    (buzzer),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {ringing, snoozing, alarm_led, buzzer, snooze_cnt[1:0]}.
    localparam logic [5:0] O_OFF = 6'b000000;
    localparam logic [5:0] O_RNG = 6'b101100;  // ringing, led on, buzzer on, cnt 0
    localparam logic [5:0] O_RDK = 6'b100000;  // ringing, led off
    localparam logic [5:0] O_SN1 = 6'b010001;  // snoozing, cnt 1

    typedef struct {
        logic       rst;
        logic       adjust;
        logic       alarm_en;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       tick;
        logic       stop;
        logic       snz;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[29];

    function automatic logic [5:0] outs();
        return {ringing, snoozing, alarm_led, buzzer, snooze_cnt};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {ring,snz,led,buz,cnt}=%b expected %b", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [5:0] s);
        time_h = 5'd7;
        time_m = 6'd30;
        time_s = s;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    // Apply n single-cycle ticks back to back and check the outputs after the last one.
    task automatic run_ticks(input int n, input string name, input logic [5:0] exp);
        tick_1hz = 1'b1;
        for (int i = 0; i < n; i++) step();
        tick_1hz = 1'b0;
        check(name, outs(), exp);
    endtask

    // Starting from ARMED, step the time 07:30:01 -> 07:30:00 to produce a fresh trigger.
    task automatic fresh_trigger(input string name, input logic [5:0] exp);
        set_time(6'd1);
        step();
        set_time(6'd0);
        step();
        check(name, outs(), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst adj en  h  m   s   tick stop snz exp
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'd7, 6'd29, 6'd59, 1'b0, 1'b0, 1'b0, O_OFF}; // reset
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd7, 6'd29, 6'd59, 1'b0, 1'b0, 1'b0, O_OFF}; // adjusting: IDLE
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd29, 6'd59, 1'b0, 1'b0, 1'b0, O_OFF}; // ARMED
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_RNG}; // trigger
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd1,  1'b1, 1'b0, 1'b0, O_RDK}; // tick: led off
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd2,  1'b1, 1'b0, 1'b0, O_RNG}; // tick: led on
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd2,  1'b0, 1'b0, 1'b0, O_RNG}; // no tick: hold
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd2,  1'b0, 1'b0, 1'b1, O_SN1}; // snooze
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd2,  1'b0, 1'b0, 1'b1, O_SN1}; // snooze ignored
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd3,  1'b1, 1'b0, 1'b0, O_SN1}; // tick in snooze
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd3,  1'b0, 1'b1, 1'b0, O_OFF}; // stop in snooze
        vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_RNG}; // new trigger
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b1, 1'b1, O_OFF}; // stop+snooze
        vecs[13] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_OFF}; // held match
        vecs[14] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd1,  1'b0, 1'b0, 1'b0, O_OFF};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_RNG}; // trigger
        vecs[16] = '{1'b0, 1'b1, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_OFF}; // adjust in RING
        vecs[17] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_OFF}; // rearm, held match
        vecs[18] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd1,  1'b0, 1'b0, 1'b0, O_OFF};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_RNG}; // trigger
        vecs[20] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd1,  1'b0, 1'b0, 1'b0, O_RNG};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_RNG}; // trigger in RING
        vecs[22] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b1, O_SN1}; // snooze
        vecs[23] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd1,  1'b0, 1'b0, 1'b0, O_SN1};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_SN1}; // trigger in SNOOZE
        vecs[25] = '{1'b0, 1'b0, 1'b0, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_OFF}; // disarm
        vecs[26] = '{1'b1, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b1, 1'b0, 1'b0, O_OFF}; // rst beats inputs
        vecs[27] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_OFF}; // IDLE ignores trigger
        vecs[28] = '{1'b0, 1'b0, 1'b1, 5'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, O_OFF}; // ARMED, held match

        alarm_h  = 5'd7;
        alarm_m  = 6'd30;
        rst      = 1'b1;
        adjust   = 1'b0;
        alarm_en = 1'b0;
        tick_1hz = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;
        set_time(6'd0);
        step();

        for (int i = 0; i < 29; i++) begin
            rst      = vecs[i].rst;
            adjust   = vecs[i].adjust;
            alarm_en = vecs[i].alarm_en;
            time_h   = vecs[i].h;
            time_m   = vecs[i].m;
            time_s   = vecs[i].s;
            tick_1hz = vecs[i].tick;
            stop     = vecs[i].stop;
            snooze   = vecs[i].snz;
            step();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        rst      = 1'b0;
        tick_1hz = 1'b0;
        stop     = 1'b0;
        snooze   = 1'b0;

        // Auto-stop: LED toggles every tick, the 60th tick ends the event.
        time_h = 5'd7; time_m = 6'd29; time_s = 6'd59;
        step();
        set_time(6'd0);
        step();
        check("a_ring_start", outs(), O_RNG);
        tick_1hz = 1'b1;
        for (int k = 1; k <= 59; k++) begin
            step();
            check($sformatf("a_tick%0d", k), outs(), (k % 2 == 0) ? O_RNG : O_RDK);
        end
        step();
        tick_1hz = 1'b0;
        check("a_timeout", outs(), O_OFF);
        for (int k = 0; k < 5; k++) step();
        check("a_no_retrigger", outs(), O_OFF);

        // Snooze runs its full length and rings again with the count kept.
        fresh_trigger("b_ring", O_RNG);
        pulse_snooze();
        check("b_snooze1", outs(), O_SN1);
        run_ticks(299, "b_snooze_hold", O_SN1);
        run_ticks(1, "b_rering", 6'b101101);

        // Two more snoozes, then the fourth acts as stop.
        pulse_snooze();
        check("c_snooze2", outs(), 6'b010010);
        run_ticks(300, "c_rering2", 6'b101110);
        pulse_snooze();
        check("c_snooze3", outs(), 6'b010011);
        run_ticks(300, "c_rering3", 6'b101111);
        pulse_snooze();
        check("c_fourth_is_stop", outs(), O_OFF);
        fresh_trigger("c_rearm_cnt0", O_RNG);

        // Reset in the middle of a snooze aborts the event; only a new trigger rings.
        pulse_snooze();
        check("d_snooze", outs(), O_SN1);
        run_ticks(10, "d_snooze_mid", O_SN1);
        rst = 1'b1;
        step();
        check("d_rst", outs(), O_OFF);
        rst = 1'b0;
        step();
        step();
        step();
        check("d_rearmed_quiet", outs(), O_OFF);
        fresh_trigger("d_new_trigger", O_RNG);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
